// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn
// Registered 1-to-N stream demultiplexer with valid/ready handshakes on the
// input and on every output channel. Each channel has its own holding register.
// In round-robin mode, an internal pointer selects the target channel.
//
// Parameters:
//   WIDTH  data bits per beat
//   SEL_W  select width; channel count N = 2**SEL_W
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    input beat
//   in_valid   producer has a beat
//   in_ready   beat is accepted this cycle (0 while rst_n is low)
//   sel        target channel in addressed mode
//   mode       0 = addressed (sel), 1 = round-robin (rr_ptr)
//   ptr_clr    synchronous clear of rr_ptr; wins over increment
//   bcast      (only with DEMUX_BCAST_EN) load every channel with the beat
//   out_data   channel i at bits [i*WIDTH +: WIDTH]
//   out_valid  per-channel valid
//   out_ready  per-channel consumer ready
//   rr_ptr     current round-robin pointer
//
// Optional feature macro: DEMUX_BCAST_EN (adds the bcast input).

module demux_stream_1xn #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         mode,
  input  logic                         ptr_clr,
`ifdef DEMUX_BCAST_EN
  input  logic                         bcast,
`endif
  output logic [(2**SEL_W)*WIDTH-1:0]  out_data,
  output logic [(2**SEL_W)-1:0]        out_valid,
  input  logic [(2**SEL_W)-1:0]        out_ready,
  output logic [SEL_W-1:0]             rr_ptr
);

  localparam int unsigned N = 2**SEL_W;

  logic             is_bcast;
  logic [SEL_W-1:0] tgt;
  logic [N-1:0]     chan_free;
  logic [N-1:0]     load;
  logic             accept;

`ifdef DEMUX_BCAST_EN
  assign is_bcast = bcast;
`else
  assign is_bcast = 1'b0;
`endif

  assign tgt       = mode ? rr_ptr : sel;
  // A channel can take a beat if it is empty or is being drained this cycle.
  assign chan_free = ~out_valid | out_ready;
  assign in_ready  = rst_n & (is_bcast ? (&chan_free) : chan_free[tgt]);
  assign accept    = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      if (is_bcast) load = '1;
      else          load[tgt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        // A load takes priority over a drain, so a channel can sustain one beat per cycle.
        if (load[i]) begin
          out_data[i*WIDTH +: WIDTH] <= in_data;
          out_valid[i]               <= 1'b1;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      // A beat accepted together with ptr_clr still uses the old pointer (through tgt).
      if (ptr_clr)
        rr_ptr <= '0;
      else if (accept && mode && !is_bcast)
        rr_ptr <= rr_ptr + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_stream_1xn.sv
// tb_demux_stream_1xn
// Self-checking bench for demux_stream_1xn. It uses a channel-array reference
// model and runs directed scenarios plus a randomized run.
// Compile with DEMUX_BCAST_EN to add the bcast port and its scenario.

module tb_demux_stream_1xn;

  localparam int WIDTH = 8;
  localparam int SEL_W = 4;
  localparam int N     = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [WIDTH-1:0]   in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [SEL_W-1:0]   sel = '0;
  logic               mode = 1'b0;
  logic               ptr_clr = 1'b0;
  logic               bcast_drv = 1'b0;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready = '1;
  logic [SEL_W-1:0]   rr_ptr;

  int checks = 0;
  int failures = 0;

  // Reference model: one holding slot per channel plus the pointer.
  logic [WIDTH-1:0] m_data[N];
  logic             m_valid[N];
  int               m_ptr;

  demux_stream_1xn #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .ptr_clr(ptr_clr),
`ifdef DEMUX_BCAST_EN
    .bcast(bcast_drv),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  function automatic int tgt();
    return mode ? m_ptr : int'(sel);
  endfunction

  function automatic logic exp_ready();
    logic r;
    int   t;
    if (bcast_drv) begin
      r = 1'b1;
      for (int i = 0; i < N; i++) r = r & (!m_valid[i] || out_ready[i]);
    end else begin
      t = tgt();
      r = !m_valid[t] || out_ready[t];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] mv();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [N*WIDTH-1:0] md();
    logic [N*WIDTH-1:0] d;
    for (int i = 0; i < N; i++) d[i*WIDTH +: WIDTH] = m_data[i];
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] ch(int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_data[i]  = '0;
      m_valid[i] = 1'b0;
    end
    m_ptr = 0;
  endtask

  // Advance one clock and apply the same transition to the model. Called at post-edge + 1 or later.
  task automatic step();
    logic acc;
    int   t;
    acc = in_valid && exp_ready();
    t   = tgt();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc && (bcast_drv || i == t)) begin
        m_data[i]  = in_data;
        m_valid[i] = 1'b1;
      end else if (m_valid[i] && out_ready[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (ptr_clr) m_ptr = 0;
    else if (acc && mode && !bcast_drv) m_ptr = (m_ptr + 1) % N;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; model_reset();
    #2;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if (out_valid !== '0 || out_data !== '0 || rr_ptr !== '0) begin
      failures++;
      $display("FAIL reset_state valid=%h data=%h ptr=%0d exp all zero", out_valid, out_data, rr_ptr);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addressed_sweep();
    mode = 1'b0; out_ready = '1;
    for (int j = 0; j < N; j++) begin
      in_valid = 1'b1; sel = SEL_W'(j); in_data = 8'hA0 + 8'(j);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL sweep_ready j=%0d got=%b exp=1", j, in_ready);
      end
      step();
      checks++;
      if (out_valid[j] !== 1'b1 || ch(j) !== 8'hA0 + 8'(j)) begin
        failures++;
        $display("FAIL sweep_chan j=%0d valid=%b data=%h exp valid=1 data=%h", j, out_valid[j], ch(j), 8'hA0 + 8'(j));
      end
      checks++;
      if (out_valid !== mv() || out_data !== md()) begin
        failures++; $display("FAIL sweep_model j=%0d valid=%h exp=%h", j, out_valid, mv());
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    mode = 1'b0; out_ready = '1; out_ready[3] = 1'b0;
    in_valid = 1'b1; sel = 4'd3; in_data = 8'h11;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_first_ready got=%b exp=1", in_ready); end
    step();
    in_data = 8'h22;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0", in_ready); end
    step();
    checks++;
    if (ch(3) !== 8'h11 || out_valid[3] !== 1'b1) begin
      failures++; $display("FAIL bp_hold data=%h valid=%b exp data=11 valid=1", ch(3), out_valid[3]);
    end
    sel = 4'd5; in_data = 8'h33;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_other_ready got=%b exp=1", in_ready); end
    step();
    checks++;
    if (ch(5) !== 8'h33 || out_valid[5] !== 1'b1) begin
      failures++; $display("FAIL bp_other_data data=%h valid=%b exp data=33 valid=1", ch(5), out_valid[5]);
    end
    sel = 4'd3; in_data = 8'h22; out_ready[3] = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    checks++;
    if (ch(3) !== 8'h22 || out_valid[3] !== 1'b1) begin
      failures++; $display("FAIL bp_release_data data=%h valid=%b exp data=22 valid=1", ch(3), out_valid[3]);
    end
    checks++;
    if (out_valid !== mv() || out_data !== md()) begin
      failures++; $display("FAIL bp_model valid=%h exp=%h", out_valid, mv());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_rr_wrap();
    logic [WIDTH-1:0] d;
    mode = 1'b1; out_ready = '1; in_valid = 1'b0; ptr_clr = 1'b1;
    step();
    ptr_clr = 1'b0; out_ready = '0;
    for (int k = 0; k < N; k++) begin
      d = 8'($urandom); in_data = d; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || rr_ptr !== SEL_W'(k)) begin
        failures++; $display("FAIL rr_fill_ready k=%0d ready=%b ptr=%0d exp ready=1 ptr=%0d", k, in_ready, rr_ptr, k);
      end
      step();
      checks++;
      if (ch(k) !== d || out_valid[k] !== 1'b1) begin
        failures++; $display("FAIL rr_fill_data k=%0d data=%h exp=%h", k, ch(k), d);
      end
    end
    // Channel 0 is full and not ready: three stalled cycles.
    for (int s = 0; s < 3; s++) begin
      in_data = 8'($urandom);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL rr_stall_ready s=%0d got=%b exp=0", s, in_ready); end
      step();
      checks++;
      if (rr_ptr !== '0) begin failures++; $display("FAIL rr_stall_ptr s=%0d got=%0d exp=0", s, rr_ptr); end
    end
    out_ready = '1;
    for (int k = 0; k < 2; k++) begin
      d = 8'($urandom); in_data = d;
      #1;
      step();
      checks++;
      if (ch(k) !== d || out_valid[k] !== 1'b1) begin
        failures++; $display("FAIL rr_wrap_data k=%0d data=%h exp=%h", k, ch(k), d);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (rr_ptr !== 4'd2) begin failures++; $display("FAIL rr_final_ptr got=%0d exp=2", rr_ptr); end
  endtask

  task automatic test_ptr_clr();
    mode = 1'b1; out_ready = '1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      #1; step();
    end
    checks++;
    if (rr_ptr !== 4'd7) begin failures++; $display("FAIL clr_setup_ptr got=%0d exp=7", rr_ptr); end
    ptr_clr = 1'b1; in_data = 8'h9E;
    #1; step();
    checks++;
    if (ch(7) !== 8'h9E || out_valid[7] !== 1'b1 || rr_ptr !== '0) begin
      failures++; $display("FAIL clr_priority data=%h valid=%b ptr=%0d exp data=9e valid=1 ptr=0", ch(7), out_valid[7], rr_ptr);
    end
    ptr_clr = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      sel       = SEL_W'($urandom);
      mode      = 1'($urandom);
      ptr_clr   = ($urandom_range(0, 15) == 0);
      out_ready = 16'($urandom);
`ifdef DEMUX_BCAST_EN
      bcast_drv = ($urandom_range(0, 9) == 0);
`endif
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        failures++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, in_ready, exp_ready());
      end
      step();
      checks++;
      if (out_valid !== mv() || out_data !== md() || rr_ptr !== SEL_W'(m_ptr)) begin
        failures++;
        $display("FAIL rand_state n=%0d valid=%h exp=%h ptr=%0d exp=%0d data=%h exp=%h", n, out_valid, mv(), rr_ptr, m_ptr, out_data, md());
      end
    end
    in_valid = 1'b0; ptr_clr = 1'b0; bcast_drv = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = '1; in_valid = 1'b0;
    step();
    mode = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    #1; step();
    mode = 1'b0; out_ready = '0; sel = 4'd2; in_data = 8'h42;
    #1; step();
    sel = 4'd9; in_data = 8'h49;
    #1; step();
    checks++;
    if (out_valid[2] !== 1'b1 || out_valid[9] !== 1'b1 || rr_ptr === '0) begin
      failures++; $display("FAIL midrst_setup valid=%h ptr=%0d exp ch2,ch9 valid and ptr nonzero", out_valid, rr_ptr);
    end
    #2; rst_n = 1'b0; model_reset();
    #1;
    checks++;
    if (out_valid !== '0 || rr_ptr !== '0 || in_ready !== 1'b0 || out_data !== '0) begin
      failures++; $display("FAIL midrst_async valid=%h ptr=%0d ready=%b exp all zero", out_valid, rr_ptr, in_ready);
    end
    #2; rst_n = 1'b1;
    #1;
    mode = 1'b1; out_ready = '1; in_valid = 1'b1; in_data = 8'hC3;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    step();
    checks++;
    if (ch(0) !== 8'hC3 || out_valid !== 16'h0001 || rr_ptr !== 4'd1) begin
      failures++; $display("FAIL midrst_first valid=%h data0=%h ptr=%0d exp valid=0001 data0=c3 ptr=1", out_valid, ch(0), rr_ptr);
    end
    in_valid = 1'b0;
  endtask

`ifdef DEMUX_BCAST_EN
  task automatic test_bcast();
    mode = 1'b1; out_ready = '1; bcast_drv = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bcast_ready got=%b exp=1", in_ready); end
    step();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ch(i) !== 8'h5A || out_valid[i] !== 1'b1) begin
        failures++; $display("FAIL bcast_chan i=%0d data=%h valid=%b exp data=5a valid=1", i, ch(i), out_valid[i]);
      end
    end
    checks++;
    if (rr_ptr !== SEL_W'(m_ptr)) begin failures++; $display("FAIL bcast_ptr got=%0d exp=%0d", rr_ptr, m_ptr); end
    out_ready = '1; out_ready[4] = 1'b0; in_data = 8'h77;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bcast_block got=%b exp=0", in_ready); end
    step();
    checks++;
    if (out_valid !== mv() || out_data !== md()) begin
      failures++; $display("FAIL bcast_model valid=%h exp=%h", out_valid, mv());
    end
    bcast_drv = 1'b0; in_valid = 1'b0;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_addressed_sweep();
    test_backpressure();
    test_rr_wrap();
    test_ptr_clr();
`ifdef DEMUX_BCAST_EN
    test_bcast();
`endif
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
